// File: rtl/axis_tracker_ctrl.sv
// axis_tracker_ctrl: two-axis tracker sequencer (theta then phi) emitting rate-limited
// step pulses, in manual target-seeking or auto photoresistor-balancing mode.
module axis_tracker_ctrl #(
   parameter int W         = 16,
   parameter int DEADBAND  = 5,
   parameter int PHI_RANGE = 360,
   parameter int STEP_DIV  = 1000,
   parameter int TIMEOUT   = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] r_v1,
   input  logic [W-1:0] r_v2,
   input  logic [W-1:0] r_h1,
   input  logic [W-1:0] r_h2,
   input  logic [W-1:0] theta_cmd,
   input  logic [W-1:0] phi_cmd,
   input  logic [W-1:0] theta_pos,
   input  logic [W-1:0] phi_pos,
   output logic         theta_up,
   output logic         theta_dn,
   output logic         phi_cw,
   output logic         phi_ccw,
   output logic         busy,
   output logic         done,
   output logic         fault
);
   typedef enum logic [2:0] {S_IDLE, S_THETA, S_PHI, S_DONE, S_FAULT} state_t;
   localparam int TW = $clog2(STEP_DIV);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic signed [W+1:0] DB   = (W+2)'(DEADBAND);
   localparam logic signed [W+1:0] PR   = (W+2)'(PHI_RANGE);
   localparam logic signed [W+1:0] PR_H = (W+2)'(PHI_RANGE / 2);
   localparam logic signed [W+1:0] PR_L = (W+2)'(PHI_RANGE - DEADBAND);

   state_t          r_state;
   logic            r_mode;
   logic [W-1:0]    r_theta_cmd, r_phi_cmd;
   logic [TW-1:0]   r_tick;
   logic [CW-1:0]   r_to;
   logic signed [W+1:0] w_dt, w_dh, w_dp, w_dm;
   logic            w_t_al, w_p_al, w_t_pos, w_p_pos, w_al, w_tick;

   function automatic logic signed [W+1:0] diff(input logic [W-1:0] a, input logic [W-1:0] b);
      return $signed({2'b00, a}) - $signed({2'b00, b});
   endfunction

   // Positive w_dt means theta must go up; positive phi metrics mean clockwise.
   always_comb begin
      w_dt    = r_mode ? diff(r_theta_cmd, theta_pos) : diff(r_v1, r_v2);
      w_dh    = diff(r_h1, r_h2);
      w_dp    = diff(r_phi_cmd, phi_pos);
      w_dm    = (w_dp < 0) ? w_dp + PR : w_dp;
      w_t_al  = (w_dt >= -DB) && (w_dt <= DB);
      w_t_pos = w_dt > 0;
      w_p_al  = r_mode ? ((w_dm <= DB) || (w_dm >= PR_L)) : ((w_dh >= -DB) && (w_dh <= DB));
      w_p_pos = r_mode ? (w_dm <= PR_H) : (w_dh > 0);
      w_al    = (r_state == S_THETA) ? w_t_al : w_p_al;
      w_tick  = r_tick == TW'(STEP_DIV - 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_mode      <= 1'b0;
         r_theta_cmd <= '0;
         r_phi_cmd   <= '0;
         r_tick      <= '0;
         r_to        <= '0;
         theta_up    <= 1'b0;
         theta_dn    <= 1'b0;
         phi_cw      <= 1'b0;
         phi_ccw     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
      end else begin
         theta_up <= 1'b0;
         theta_dn <= 1'b0;
         phi_cw   <= 1'b0;
         phi_ccw  <= 1'b0;
         done     <= 1'b0;
         case (r_state)
            S_IDLE: if (start) begin
               r_mode      <= mode;
               r_theta_cmd <= theta_cmd;
               r_phi_cmd   <= phi_cmd;
               r_tick      <= '0;
               r_to        <= '0;
               if (mode && (phi_cmd >= W'(PHI_RANGE))) begin
                  r_state <= S_FAULT;
                  fault   <= 1'b1;
               end else begin
                  r_state <= S_THETA;
                  busy    <= 1'b1;
                  fault   <= 1'b0;
               end
            end
            S_THETA, S_PHI: if (!w_tick) begin
               r_tick <= r_tick + 1'b1;
            end else begin
               r_tick <= '0;
               if (w_al) begin
                  r_to <= '0;
                  if (r_state == S_THETA) begin
                     r_state <= S_PHI;
                  end else begin
                     r_state <= S_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end else if (r_to == CW'(TIMEOUT)) begin
                  r_state <= S_FAULT;
                  busy    <= 1'b0;
                  fault   <= 1'b1;
               end else begin
                  r_to <= r_to + 1'b1;
                  if (r_state == S_THETA) begin
                     theta_up <= w_t_pos;
                     theta_dn <= !w_t_pos;
                  end else begin
                     phi_cw  <= w_p_pos;
                     phi_ccw <= !w_p_pos;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_tracker_ctrl.sv
// tb_axis_tracker_ctrl: directed vector table plus multi-cycle sequences for axis_tracker_ctrl.
module tb_axis_tracker_ctrl;
   localparam int W = 16;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
   logic [W-1:0] r_v1, r_v2, r_h1, r_h2, theta_cmd, phi_cmd, theta_pos, phi_pos;
   logic theta_up, theta_dn, phi_cw, phi_ccw, busy, done, fault;
   int n_vec = 0, n_err = 0;

   axis_tracker_ctrl #(.W(W), .DEADBAND(5), .PHI_RANGE(360), .STEP_DIV(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .r_v1(r_v1), .r_v2(r_v2), .r_h1(r_h1), .r_h2(r_h2),
      .theta_cmd(theta_cmd), .phi_cmd(phi_cmd), .theta_pos(theta_pos), .phi_pos(phi_pos),
      .theta_up(theta_up), .theta_dn(theta_dn), .phi_cw(phi_cw), .phi_ccw(phi_ccw),
      .busy(busy), .done(done), .fault(fault)
   );

   always #5 clk = ~clk;

   // obs bits: {theta_up, theta_dn, phi_cw, phi_ccw, busy, done, fault}
   typedef struct {
      string        name;
      logic         md;
      logic [W-1:0] tc, pc, tp, pp, v1, v2, h1, h2;
      logic [6:0]   exp1, exp2;
   } vec_t;

   function automatic logic [6:0] obs();
      return {theta_up, theta_dn, phi_cw, phi_ccw, busy, done, fault};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic set_in(input logic md, input logic [W-1:0] tc, pc, tp, pp, v1, v2, h1, h2);
      mode = md; theta_cmd = tc; phi_cmd = pc; theta_pos = tp; phi_pos = pp;
      r_v1 = v1; r_v2 = v2; r_h1 = h1; r_h2 = h2;
   endtask

   vec_t vt[$];

   initial begin
      vt.push_back('{"man_theta_up",  1, 100,   0,  90,   0,   0,   0,   0,   0, 7'b1000100, 7'b1000100});
      vt.push_back('{"man_theta_dn",  1,  90,   0, 100,   0,   0,   0,   0,   0, 7'b0100100, 7'b0100100});
      vt.push_back('{"theta_wide_dn", 1,   0,   0, 16'hFFFF, 0, 0,   0,   0,   0, 7'b0100100, 7'b0100100});
      vt.push_back('{"phi_wrap_cw",   1, 100,  10,  95, 350,   0,   0,   0,   0, 7'b0000100, 7'b0010100});
      vt.push_back('{"phi_wrap_ccw",  1, 100, 350, 100,  10,   0,   0,   0,   0, 7'b0000100, 7'b0001100});
      vt.push_back('{"phi_tie_cw",    1,   0, 180,   0,   0,   0,   0,   0,   0, 7'b0000100, 7'b0010100});
      vt.push_back('{"phi_181_ccw",   1,   0, 181,   0,   0,   0,   0,   0,   0, 7'b0000100, 7'b0001100});
      vt.push_back('{"phi_db_lo",     1,   0,   5,   0,   0,   0,   0,   0,   0, 7'b0000100, 7'b0000010});
      vt.push_back('{"phi_db_hi",     1,   0, 355,   0,   0,   0,   0,   0,   0, 7'b0000100, 7'b0000010});
      vt.push_back('{"phi_354_ccw",   1,   0, 354,   0,   0,   0,   0,   0,   0, 7'b0000100, 7'b0001100});
      vt.push_back('{"phi_6_cw",      1,   0,   6,   0,   0,   0,   0,   0,   0, 7'b0000100, 7'b0010100});
      vt.push_back('{"auto_up",       0,   0,   0,   0,   0, 106, 100,   0,   0, 7'b1000100, 7'b1000100});
      vt.push_back('{"auto_dn",       0,   0,   0,   0,   0, 100, 106,   0,   0, 7'b0100100, 7'b0100100});
      vt.push_back('{"auto_db_done",  0, 999, 400,   0,   0, 105, 100,  50,  50, 7'b0000100, 7'b0000010});
      vt.push_back('{"auto_cw",       0,   0,   0,   0,   0, 100, 100, 200, 100, 7'b0000100, 7'b0010100});
      vt.push_back('{"auto_ccw",      0,   0,   0,   0,   0, 100, 100, 100, 200, 7'b0000100, 7'b0001100});
      vt.push_back('{"phi_cmd_bad",   1,   0, 400,   0,   0,   0,   0,   0,   0, 7'b0000001, 7'b0000001});
   end

   initial begin
      logic stray;
      int first, np, ndn, nd;
      #2;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      chk("reset_outputs", 32'(obs()), 32'h0);

      foreach (vt[k]) begin
         do_reset();
         set_in(vt[k].md, vt[k].tc, vt[k].pc, vt[k].tp, vt[k].pp, vt[k].v1, vt[k].v2, vt[k].h1, vt[k].h2);
         do_start();
         stray = 1'b0;
         for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 4) chk({vt[k].name, "_tick1"}, 32'(obs()), 32'(vt[k].exp1));
            else if (c == 8) chk({vt[k].name, "_tick2"}, 32'(obs()), 32'(vt[k].exp2));
            else if (obs()[6:3] != 4'b0) stray = 1'b1;
         end
         chk({vt[k].name, "_offtick"}, 32'(stray), 32'h0);
      end

      // manual theta convergence with position feedback
      do_reset();
      set_in(1, 100, 0, 90, 0, 0, 0, 0, 0);
      do_start();
      first = -1; np = 0; ndn = 0; nd = 0;
      for (int c = 1; c <= 200 && nd == 0; c++) begin
         step();
         if (theta_up) begin
            if (first < 0) first = c;
            np++;
            theta_pos = theta_pos + 1'b1;
         end
         if (theta_dn) ndn++;
         if (done) nd++;
      end
      chk("conv_first_pulse_clk", 32'(first), 32'd4);
      chk("conv_pulses", 32'(np), 32'd5);
      chk("conv_no_dn", 32'(ndn), 32'd0);
      chk("conv_pos", 32'(theta_pos), 32'd95);
      chk("conv_done", 32'(nd), 32'd1);
      step();
      chk("conv_done_1clk", 32'(obs()), 32'h0);

      // auto: up, then within deadband, then horizontal balanced
      do_reset();
      set_in(0, 0, 0, 0, 0, 106, 100, 70, 70);
      do_start();
      repeat (4) step();
      chk("auto_seq_up", 32'(obs()), 32'b1000100);
      r_v1 = 105;
      repeat (4) step();
      chk("auto_seq_to_phi", 32'(obs()), 32'b0000100);
      repeat (4) step();
      chk("auto_seq_done", 32'(obs()), 32'b0000010);

      // timeout with frozen position
      do_reset();
      set_in(1, 100, 0, 50, 0, 0, 0, 0, 0);
      do_start();
      np = 0; nd = 0;
      for (int c = 1; c <= 200 && !fault; c++) begin
         step();
         if (theta_up) np++;
         if (done) nd++;
      end
      chk("to_pulses", 32'(np), 32'd8);
      chk("to_fault_busy_done", 32'({fault, busy, nd[0]}), 32'b100);
      repeat (3) step();
      chk("to_fault_sticky", 32'(obs()), 32'b0000001);
      set_in(0, 0, 0, 0, 0, 10, 10, 10, 10);
      do_start();
      chk("to_restart_clears", 32'({fault, busy}), 32'b01);

      // start while busy ignored; latched manual cmd keeps driving
      do_reset();
      set_in(1, 100, 0, 90, 0, 0, 0, 0, 0);
      do_start();
      step();
      set_in(0, 0, 0, 90, 0, 7, 7, 7, 7);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("busy_start_ignored", 32'(obs()), 32'b1000100);

      // bad phi_cmd: fault right after start, no pulses
      do_reset();
      set_in(1, 100, 400, 0, 0, 0, 0, 0, 0);
      do_start();
      chk("badphi_immediate", 32'(obs()), 32'b0000001);

      // async reset between ticks
      do_reset();
      set_in(1, 100, 0, 90, 0, 0, 0, 0, 0);
      do_start();
      step();
      step();
      #2 rst = 1'b1;
      #1 chk("rst_async_outputs", 32'(obs()), 32'h0);
      step();
      rst = 1'b0;
      stray = 1'b0;
      repeat (12) begin
         step();
         if (obs() != 7'b0) stray = 1'b1;
      end
      chk("rst_no_pulses_after", 32'(stray), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
